// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - request/response and APB bus bundle for apb_master
interface apb_master_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] pADDR;
  logic          pSEL;
  logic          pENABLE;
  logic          pWRITE;
  logic [DW-1:0] pWDATA;
  logic [DW-1:0] pRDATA;
  logic          pREADY;
  logic          pSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  pRDATA, pREADY, pSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output pADDR, pSEL, pENABLE, pWRITE, pWDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output pRDATA, pREADY, pSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  pADDR, pSEL, pENABLE, pWRITE, pWDATA
  );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master with wait-state timeout
module apb_master #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic          pCLK,
  input logic          pRESET,
  apb_master_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_M1 = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          write_q;
  logic          err_q;
  logic          to_q;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          req_ready_c, psel_c, penable_c, rsp_valid_c;

  assign timeout_hit = (TIMEOUT > 0) && !bus.pREADY && (wait_cnt == TO_M1);

  always_ff @(posedge pCLK or posedge pRESET) begin
    if (pRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_nxt = SETUP;
      end
      SETUP: begin
        psel_c    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        if (bus.pREADY || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are captured once at acceptance and held until the next command.
  always_ff @(posedge pCLK or posedge pRESET) begin
    if (pRESET) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            write_q  <= bus.req_write;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (bus.pREADY) begin
            rdata_q <= (!write_q && !bus.pSLVERR) ? bus.pRDATA : '0;
            err_q   <= bus.pSLVERR;
            to_q    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              to_q    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.pSEL        = psel_c;
  assign bus.pENABLE     = penable_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.pADDR       = addr_q;
  assign bus.pWDATA      = wdata_q;
  assign bus.pWRITE      = write_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = to_q;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed scoreboard bench for apb_master
module tb_apb_master;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  logic pCLK = 1'b0;
  logic pRESET = 1'b1;
  int   errors = 0;
  int   checks = 0;
  rsp_t sb[$];

  apb_master_if #(.DW(32), .AW(32)) bus ();

  apb_master #(.DW(32), .AW(32), .TIMEOUT(TO)) u_dut (
    .pCLK  (pCLK),
    .pRESET(pRESET),
    .bus   (bus)
  );

  always #5 pCLK = ~pCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer: accept, SETUP, ACCESS with `waits` wait states, RESP held `hold` cycles.
  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, input logic se,
                          input int hold, input bit is_to, input bit pend);
    rsp_t exp, got;
    int acc, cyc;
    exp.rdata = (is_to || w || se) ? 32'h0 : rd;
    exp.err   = is_to ? 1'b1 : se;
    exp.to    = is_to;
    sb.push_back(exp);

    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    bus.req_wdata = wd;
    bus.pREADY    = 1'b1;
    bus.pSLVERR   = 1'b1;
    bus.pRDATA    = 32'hBAD0BAD0;
    @(negedge pCLK);
    bus.req_valid = 1'b0;
    bus.pREADY    = 1'b0;
    check("setup_psel", bus.pSEL, 1'b1);
    check("setup_penable", bus.pENABLE, 1'b0);
    check("setup_addr", bus.pADDR, a);
    check("setup_write", bus.pWRITE, w);
    if (w) check("setup_wdata", bus.pWDATA, wd);
    @(negedge pCLK);
    acc = 0;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 60) begin
      if (bus.pSEL && bus.pENABLE) begin
        acc++;
        check("access_addr", bus.pADDR, a);
        if (w) check("access_wdata", bus.pWDATA, wd);
        if (!is_to && acc > waits) begin
          bus.pREADY  = 1'b1;
          bus.pRDATA  = rd;
          bus.pSLVERR = se;
        end else begin
          bus.pREADY  = 1'b0;
          bus.pRDATA  = 32'hBAD0BAD0;
          bus.pSLVERR = 1'b1;
        end
      end
      @(negedge pCLK);
      cyc++;
    end
    bus.pREADY  = 1'b0;
    bus.pSLVERR = 1'b0;
    check("rsp_wait", bus.rsp_valid, 1'b1);
    check("access_cycles", acc, is_to ? TO : waits + 1);
    check("resp_psel", bus.pSEL, 1'b0);

    check("sb_nonempty", sb.size() != 0, 1'b1);
    got = (sb.size() != 0) ? sb.pop_front() : '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      if (pend) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_write = 1'b0;
      end
      check("rsp_valid", bus.rsp_valid, 1'b1);
      check("rsp_rdata", bus.rsp_rdata, got.rdata);
      check("rsp_err", bus.rsp_err, got.err);
      check("rsp_timeout", bus.rsp_timeout, got.to);
      check("resp_req_ready", bus.req_ready, 1'b0);
      check("resp_addr", bus.pADDR, a);
      if (i < hold) @(negedge pCLK);
    end
    bus.rsp_ready = 1'b1;
    @(negedge pCLK);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.pRDATA    = '0;
    bus.pREADY    = 1'b0;
    bus.pSLVERR   = 1'b0;
    repeat (2) @(negedge pCLK);
    check("rst_psel", bus.pSEL, 1'b0);
    check("rst_penable", bus.pENABLE, 1'b0);
    check("rst_pwrite", bus.pWRITE, 1'b0);
    check("rst_paddr", bus.pADDR, 32'h0);
    check("rst_pwdata", bus.pWDATA, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_to", bus.rsp_timeout, 1'b0);
    pRESET = 1'b0;
    @(negedge pCLK);

    run_xfer(32'h00, 1'b1, 32'h3, 0, 32'h12345678, 1'b0, 0, 1'b0, 1'b0);
    run_xfer(32'h04, 1'b0, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b0);
    run_xfer(32'h0C, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b1, 0, 1'b0, 1'b0);
    run_xfer(32'h10, 1'b0, 32'h0, 0, 32'h0, 1'b0, 0, 1'b1, 1'b0);
    run_xfer(32'h20, 1'b0, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 5, 1'b0, 1'b1);
    run_xfer(32'h40, 1'b0, 32'h0, 0, 32'h01020304, 1'b0, 0, 1'b0, 1'b0);

    // Abort mid-ACCESS with an asynchronous reset pulse.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h80;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h55;
    @(negedge pCLK);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge pCLK);
    check("abort_in_access", bus.pENABLE, 1'b1);
    #2 pRESET = 1'b1;
    #1;
    check("abort_psel", bus.pSEL, 1'b0);
    check("abort_penable", bus.pENABLE, 1'b0);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge pCLK);
    pRESET = 1'b0;
    check("abort_req_ready", bus.req_ready, 1'b1);
    repeat (3) begin
      @(negedge pCLK);
      check("abort_no_rsp", bus.rsp_valid, 1'b0);
    end
    run_xfer(32'h84, 1'b0, 32'h0, 2, 32'h0BADCAFE, 1'b0, 1, 1'b0, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
